mem_bridge: RTL and testbench
=============================

MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 SHALL have parameter T_RD, default 2, meaning SRAM read-strobe cycles (1..15).
REQ-002 SHALL have parameter T_WR, default 2, meaning SRAM write-pulse cycles (1..15).
REQ-003 SHALL have port clock, in, 1 bit: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, in, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port address, in, 20 bits: CPU byte address.
REQ-006 SHALL have port out, in, 8 bits: CPU write data.
REQ-007 SHALL have port we, in, 1 bit: CPU write request; 0 means the cycle is a read.
REQ-008 SHALL have port in, out, 8 bits: read data to the CPU.
REQ-009 SHALL have port chipen, out, 1 bit: CPU clock-enable; 0 stalls the CPU, which holds address/out/we stable.
REQ-010 SHALL have port sram_a, out, 19 bits: SRAM word address.
REQ-011 SHALL have port sram_dq_i, in, 16 bits: SRAM read data.
REQ-012 SHALL have port sram_dq_o, out, 16 bits: SRAM write data.
REQ-013 SHALL have port sram_dq_oe, out, 1 bit: data bus drive enable.
REQ-014 SHALL have ports sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n and sram_lb_n, out, 1 bit each: active-low SRAM strobes (ub = odd byte, lb = even byte).

Function
REQ-015 Every CPU clock with chipen=1 SHALL be treated as one access: a read when we=0, a write when we=1.
REQ-016 The block SHALL hold a one-word read buffer: buf_data[15:0], buf_tag = word address, buf_valid.
REQ-017 A hit SHALL be state IDLE, we=0, buf_valid=1 and address[19:1]==buf_tag.
REQ-018 On a hit, chipen SHALL be 1 combinationally and in SHALL be buf_data[15:8] when address[0]=1, else buf_data[7:0]; zero-wait.
REQ-019 States SHALL be IDLE, RD, WR_SETUP, WR_PULSE and WR_DONE, with a 4-bit cycle counter.
REQ-020 In IDLE on a read miss: chipen=0; next state RD.
REQ-021 In RD: ce_n=0, oe_n=0, ub_n=0, lb_n=0, sram_a=address[19:1], counted for T_RD cycles; on the last cycle sram_dq_i SHALL be latched into buf_data, buf_tag set, buf_valid=1, then IDLE, where the access hits; read-miss stall = T_RD+1 cycles.
REQ-022 In IDLE with we=1: chipen=0; next state WR_SETUP.
REQ-023 In WR_SETUP: ce_n=0, dq_oe=1, dq_o={out,out}, byte lane by address[0], we_n=1; lasts 1 cycle.
REQ-024 In WR_PULSE: as WR_SETUP but we_n=0, lasting T_WR cycles; then WR_DONE.
REQ-025 In WR_DONE: we_n=1, dq_oe and ce_n still asserted (hold), chipen=1 for exactly one cycle so the CPU retires the write; then IDLE.
REQ-026 Write stall SHALL be T_WR+2 cycles (IDLE, WR_SETUP, WR_PULSE×T_WR) before the WR_DONE retire cycle.
REQ-027 When a write matches buf_tag and buf_valid=1, the addressed byte of buf_data SHALL be updated at WR_DONE; the other byte is unchanged.
REQ-028 chipen SHALL be 0 in RD, WR_SETUP and WR_PULSE.
REQ-029 Outside RD, WR_SETUP, WR_PULSE and WR_DONE, all SRAM strobes SHALL be 1 and dq_oe=0.
REQ-030 we_n and oe_n SHALL never be 0 in the same cycle.
REQ-031 The counter SHALL not wrap: T_RD/T_WR=15 is the maximum count.

Reset
REQ-032 reset=1 SHALL force IDLE, counter=0, buf_valid=0, chipen=0, in=8'h00, all SRAM strobes=1, dq_oe=0, sram_a=0, dq_o=0, taking effect at the next edge from any state.
REQ-033 A write aborted mid-pulse by reset SHALL have we_n=1 from the first reset cycle; SRAM content is undefined for that byte.
REQ-034 The first access after reset release SHALL be a miss.

Structure
REQ-035 The state encoding and the T_RD/T_WR defaults SHALL live in a shared package, mem_pkg.
REQ-036 Sub-module: none required; a single flat module is sufficient.

Verification
REQ-037 After reset, read 20'hFFFF0 with SRAM word 16'hEA90 → chipen low 3 cycles, then in=8'h90 and chipen=1.
REQ-038 Immediate read of 20'hFFFF1 → zero-wait hit, in=8'hEA, no oe_n activity.
REQ-039 Write 8'h5A to 20'h00101 → ub_n=0, lb_n=1, we_n low 2 cycles, sram_a=19'h00080, chipen high exactly one cycle in WR_DONE.
REQ-040 Read 20'hFFFF0, then write 8'h11 to 20'hFFFF1, then read 20'hFFFF1 → hit, in=8'h11, buffer low byte still 8'h90.
REQ-041 Assert reset in the second WR_PULSE cycle → we_n=1, chipen=0, buf_valid=0 on the next edge; the following read is a miss.
REQ-042 A scoreboard SHALL check across all tests that oe_n and we_n are never both 0, and that chipen=0 throughout every RD or WR_PULSE state.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the mem_bridge CPU-to-SRAM bridge.
//   - state_t     : FSM state encoding
//   - T_*_DEFAULT : default SRAM strobe lengths in clock cycles
//   - sel_byte    : picks the CPU byte out of a 16-bit SRAM word
//   - merge_byte  : replaces one byte lane of a 16-bit word
package mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_DONE  = 3'd4
    } state_t;

    localparam int T_RD_DEFAULT = 2;
    localparam int T_WR_DEFAULT = 2;

    // Odd byte addresses live in the upper lane of the SRAM word.
    function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic odd);
        logic [7:0] result;
        if (odd) begin
            result = word[15:8];
        end else begin
            result = word[7:0];
        end
        return result;
    endfunction

    function automatic logic [15:0] merge_byte(input logic [15:0] word,
                                               input logic [7:0]  data,
                                               input logic        odd);
        logic [15:0] result;
        if (odd) begin
            result = {data, word[7:0]};
        end else begin
            result = {word[15:8], data};
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_bridge.sv
// mem_bridge: bridges an 8-bit stallable CPU bus onto a 16-bit asynchronous SRAM.
// A one-word read buffer gives zero-wait reads when the CPU stays in the same word;
// every other access stalls the CPU (chipen=0) while the SRAM strobes are sequenced.
// Ports:
//   clock, reset           : system clock, synchronous active-high reset
//   address, out, we       : CPU byte address, write data, write request
//   in, chipen             : CPU read data, CPU clock-enable (0 = stall)
//   sram_a, sram_dq_i/o/oe : SRAM word address, data in/out, data drive enable
//   sram_ce_n/oe_n/we_n    : active-low SRAM chip/output/write enables
//   sram_ub_n/lb_n         : active-low byte lanes (ub = odd byte, lb = even byte)
module mem_bridge
    import mem_pkg::*;
#(
    parameter int T_RD = T_RD_DEFAULT,
    parameter int T_WR = T_WR_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] address,
    input  logic [7:0]  out,
    input  logic        we,
    output logic [7:0]  in,
    output logic        chipen,
    output logic [18:0] sram_a,
    input  logic [15:0] sram_dq_i,
    output logic [15:0] sram_dq_o,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    localparam logic [3:0] RD_LAST = 4'(T_RD - 1);
    localparam logic [3:0] WR_LAST = 4'(T_WR - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [15:0] r_buf_data;
    logic [18:0] r_buf_tag;
    logic        r_buf_valid;
    logic [18:0] r_sram_a;
    logic [15:0] r_dq_o;
    logic        r_dq_oe;
    logic        r_ce_n;
    logic        r_oe_n;
    logic        r_we_n;
    logic        r_ub_n;
    logic        r_lb_n;
    logic        w_hit;

    assign sram_a     = r_sram_a;
    assign sram_dq_o  = r_dq_o;
    assign sram_dq_oe = r_dq_oe;
    assign sram_ce_n  = r_ce_n;
    assign sram_oe_n  = r_oe_n;
    assign sram_we_n  = r_we_n;
    assign sram_ub_n  = r_ub_n;
    assign sram_lb_n  = r_lb_n;

    // Buffer hit detection and CPU-side handshake; hits bypass the FSM entirely.
    always_comb begin
        w_hit = (r_state == ST_IDLE) && !we && r_buf_valid && (address[19:1] == r_buf_tag);
        if (w_hit) begin
            chipen = 1'b1;
            in     = sel_byte(r_buf_data, address[0]);
        end else begin
            chipen = (r_state == ST_WR_DONE);
            in     = 8'h00;
        end
    end

    // Access sequencer: strobes are loaded together with the state they belong to,
    // so every SRAM pin comes straight from a flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_buf_valid <= 1'b0;
            r_buf_data  <= 16'h0000;
            r_buf_tag   <= 19'h00000;
            r_sram_a    <= 19'h00000;
            r_dq_o      <= 16'h0000;
            r_dq_oe     <= 1'b0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_ub_n      <= 1'b1;
            r_lb_n      <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_sram_a <= address[19:1];
                        r_ce_n   <= 1'b0;
                        r_cnt    <= 4'd0;
                        if (we) begin
                            r_state <= ST_WR_SETUP;
                            r_dq_oe <= 1'b1;
                            r_dq_o  <= {out, out};
                            r_ub_n  <= ~address[0];
                            r_lb_n  <= address[0];
                        end else begin
                            r_state <= ST_RD;
                            r_oe_n  <= 1'b0;
                            r_ub_n  <= 1'b0;
                            r_lb_n  <= 1'b0;
                        end
                    end
                end
                ST_RD: begin
                    if (r_cnt == RD_LAST) begin
                        r_buf_data  <= sram_dq_i;
                        r_buf_tag   <= r_sram_a;
                        r_buf_valid <= 1'b1;
                        r_ce_n      <= 1'b1;
                        r_oe_n      <= 1'b1;
                        r_ub_n      <= 1'b1;
                        r_lb_n      <= 1'b1;
                        r_cnt       <= 4'd0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_WR_SETUP: begin
                    r_we_n  <= 1'b0;
                    r_cnt   <= 4'd0;
                    r_state <= ST_WR_PULSE;
                end
                ST_WR_PULSE: begin
                    if (r_cnt == WR_LAST) begin
                        // Data and chip enable stay driven through WR_DONE for hold time.
                        r_we_n  <= 1'b1;
                        r_cnt   <= 4'd0;
                        r_state <= ST_WR_DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_WR_DONE: begin
                    // Keep the buffer coherent with the byte just written.
                    if (r_buf_valid && (r_buf_tag == r_sram_a)) begin
                        r_buf_data <= merge_byte(r_buf_data, r_dq_o[7:0], ~r_ub_n);
                    end else begin
                        r_buf_data <= r_buf_data;
                    end
                    r_dq_oe <= 1'b0;
                    r_dq_o  <= 16'h0000;
                    r_ce_n  <= 1'b1;
                    r_ub_n  <= 1'b1;
                    r_lb_n  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_dq_oe <= 1'b0;
                    r_ce_n  <= 1'b1;
                    r_oe_n  <= 1'b1;
                    r_we_n  <= 1'b1;
                    r_ub_n  <= 1'b1;
                    r_lb_n  <= 1'b1;
                    r_cnt   <= 4'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: self-checking bench for mem_bridge (T_RD = T_WR = 2).
// A small SRAM model answers reads and absorbs writes; expected CPU read bytes
// are queued when an access is driven and compared when the CPU retires it.
module tb_mem_bridge;

    logic        clock;
    logic        reset;
    logic [19:0] address;
    logic [7:0]  out;
    logic        we;
    logic [7:0]  in;
    logic        chipen;
    logic [18:0] sram_a;
    logic [15:0] sram_dq_i;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  sb_q[$];
    logic [15:0] mem [0:255];
    logic        preload;

    // values captured during the most recent access
    int          last_stall;
    int          last_we_low;
    int          last_oe_low;
    logic        last_first_ce_n;
    logic [4:0]  last_pulse_pins;   // {ub_n, lb_n, dq_oe, ce_n, oe_n} during first we_n-low cycle
    logic [18:0] last_pulse_a;
    logic [15:0] last_pulse_dq;
    logic [2:0]  last_done_pins;    // {we_n, ce_n, dq_oe} in the retire cycle

    typedef struct {
        logic [19:0] addr;
        logic [7:0]  data;
        logic        wr;
        int          stall;
        logic [7:0]  rd;
    } vec_t;
    vec_t vecs[10];

    mem_bridge #(.T_RD(2), .T_WR(2)) dut (
        .clock(clock), .reset(reset), .address(address), .out(out), .we(we),
        .in(in), .chipen(chipen), .sram_a(sram_a), .sram_dq_i(sram_dq_i),
        .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
        .sram_lb_n(sram_lb_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // SRAM model: 256 aliased words, byte-lane writes while ce_n and we_n are low.
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
            mem[8'hF8] = 16'hEA90;
            mem[8'h80] = 16'h3C4B;
            mem[8'h10] = 16'h7788;
        end else if (!sram_ce_n && !sram_we_n) begin
            if (!sram_ub_n) mem[sram_a[7:0]][15:8] = sram_dq_o[15:8];
            if (!sram_lb_n) mem[sram_a[7:0]][7:0]  = sram_dq_o[7:0];
        end
    end

    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_a[7:0]] : 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus-wide safety monitor: no simultaneous oe_n/we_n, CPU stalled while strobing.
    always @(negedge clock) begin
        if (!sram_oe_n || !sram_we_n) begin
            chk("mon_oe_we_exclusive", {31'd0, (!sram_oe_n && !sram_we_n)}, 32'd0);
            chk("mon_chipen_in_strobe", {31'd0, chipen}, 32'd0);
        end
    end

    // Drives one CPU access (caller is just after a rising edge) and runs it to retire.
    task automatic access(input logic [19:0] a, input logic [7:0] d, input logic w,
                          input int exp_stall, input logic [7:0] exp_rd, input string name);
        bit   done;
        logic [7:0] got;
        address = a; out = d; we = w;
        if (!w) sb_q.push_back(exp_rd);
        done = 1'b0; got = 8'h00;
        last_stall = 0; last_we_low = 0; last_oe_low = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clock);
            if (c == 0) last_first_ce_n = sram_ce_n;
            if (!sram_oe_n) last_oe_low++;
            if (!sram_we_n) begin
                last_we_low++;
                if (last_we_low == 1) begin
                    last_pulse_pins = {sram_ub_n, sram_lb_n, sram_dq_oe, sram_ce_n, sram_oe_n};
                    last_pulse_a    = sram_a;
                    last_pulse_dq   = sram_dq_o;
                end
            end
            if (chipen) begin
                done = 1'b1;
                got  = in;
                last_done_pins = {sram_we_n, sram_ce_n, sram_dq_oe};
            end else begin
                last_stall++;
            end
            @(posedge clock); #1;
        end
        chk({name, "_retired"}, {31'd0, done}, 32'd1);
        chk({name, "_stall"}, 32'(last_stall), 32'(exp_stall));
        if (!w) begin
            if (sb_q.size() > 0) begin
                chk({name, "_rdata"}, {24'd0, got}, {24'd0, sb_q.pop_front()});
            end else begin
                chk({name, "_sb_empty"}, 32'd1, 32'd0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{20'h00100, 8'h00, 1'b0, 0, 8'h4B};
        vecs[1] = '{20'hFFFF0, 8'h00, 1'b0, 3, 8'h90};
        vecs[2] = '{20'hFFFF1, 8'h11, 1'b1, 4, 8'h00};
        vecs[3] = '{20'hFFFF1, 8'h00, 1'b0, 0, 8'h11};
        vecs[4] = '{20'hFFFF0, 8'h00, 1'b0, 0, 8'h90};
        vecs[5] = '{20'h00020, 8'h00, 1'b0, 3, 8'h88};
        vecs[6] = '{20'h00021, 8'h00, 1'b0, 0, 8'h77};
        vecs[7] = '{20'h00020, 8'hC3, 1'b1, 4, 8'h00};
        vecs[8] = '{20'h00020, 8'h00, 1'b0, 0, 8'hC3};
        vecs[9] = '{20'h00021, 8'h00, 1'b0, 0, 8'h77};

        preload = 1'b1; reset = 1'b1;
        address = 20'hFFFF0; out = 8'h00; we = 1'b0;
        repeat (3) @(posedge clock);
        preload = 1'b0;
        @(negedge clock);
        chk("reset_chipen", {31'd0, chipen}, 32'd0);
        chk("reset_in", {24'd0, in}, 32'd0);
        chk("reset_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        chk("reset_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("reset_sram_a", {13'd0, sram_a}, 32'd0);
        chk("reset_dq_o", {16'd0, sram_dq_o}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // First access after reset misses; the odd byte of the same word then hits.
        access(20'hFFFF0, 8'h00, 1'b0, 3, 8'h90, "first_read_miss");
        chk("first_read_oe_cycles", 32'(last_oe_low), 32'd2);
        access(20'hFFFF1, 8'h00, 1'b0, 0, 8'hEA, "hit_odd");
        chk("hit_no_oe", 32'(last_oe_low), 32'd0);

        // Odd-byte write: lane, address, data and pulse length.
        access(20'h00101, 8'h5A, 1'b1, 4, 8'h00, "write_odd");
        chk("write_we_cycles", 32'(last_we_low), 32'd2);
        chk("write_pins", {27'd0, last_pulse_pins}, {27'd0, 5'b01101});
        chk("write_sram_a", {13'd0, last_pulse_a}, 32'h00080);
        chk("write_dq_o", {16'd0, last_pulse_dq}, 32'h5A5A);
        chk("write_done_hold", {29'd0, last_done_pins}, {29'd0, 3'b101});
        access(20'h00101, 8'h00, 1'b0, 3, 8'h5A, "read_after_write");
        chk("post_done_ce_released", {31'd0, last_first_ce_n}, 32'd1);

        foreach (vecs[i]) begin
            access(vecs[i].addr, vecs[i].data, vecs[i].wr, vecs[i].stall, vecs[i].rd,
                   $sformatf("vec%0d", i));
        end

        // Reset during the second write-pulse cycle aborts the write and drops the buffer.
        address = 20'h00050; out = 8'hAA; we = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("abort_in_pulse", {31'd0, sram_we_n}, 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("abort_chipen", {31'd0, chipen}, 32'd0);
        chk("abort_ce_n", {31'd0, sram_ce_n}, 32'd1);
        chk("abort_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        reset = 1'b0; we = 1'b0;
        access(20'h00020, 8'h00, 1'b0, 3, 8'hC3, "post_abort_miss");
        access(20'h00021, 8'h00, 1'b0, 0, 8'h77, "post_abort_hit");

        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
